// File: rtl/bp_me_burst_to_lite.sv
// bp_me_burst_to_lite
//   Collects one BedRock burst message (a header plus zero or more data beats)
//   and presents it as a single lite message {data, header}, with the header
//   in the LSBs. Messages shorter than the block have their filled region
//   replicated across the whole payload.
//
// Ports
//   clk_i                     clock
//   reset_i                   synchronous, active-high reset
//   in_msg_header_i/_v_i      burst header and its valid
//   in_msg_header_ready_and_o header ready (transfer on valid & ready)
//   in_msg_data_i/_v_i        burst data beat and its valid
//   in_msg_data_ready_and_o   beat ready
//   out_msg_o                 lite message {data, header}
//   out_msg_v_o               lite message valid
//   out_msg_ready_and_i       downstream ready (transfer on valid & ready)
//
// Optional build macro
//   BP_ME_BURST_TO_LITE_PROTOCOL_CHECK_EN : compiles in simulation-only
//   protocol checks that report through $error.

module bp_me_burst_to_lite #(
    parameter int          header_width_p    = 0,
    parameter int          in_data_width_p   = 64,
    parameter int          out_data_width_p  = 512,
    parameter int          size_offset_p     = 0,
    parameter int          msg_type_offset_p = 3,
    parameter logic [15:0] payload_mask_p    = 16'h0
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,

    input  logic [header_width_p-1:0]                 in_msg_header_i,
    input  logic                                      in_msg_header_v_i,
    output logic                                      in_msg_header_ready_and_o,

    input  logic [in_data_width_p-1:0]                in_msg_data_i,
    input  logic                                      in_msg_data_v_i,
    output logic                                      in_msg_data_ready_and_o,

    output logic [header_width_p+out_data_width_p-1:0] out_msg_o,
    output logic                                      out_msg_v_o,
    input  logic                                      out_msg_ready_and_i
);

    localparam int max_beats_lp = out_data_width_p / in_data_width_p;
    localparam int cnt_w_lp     = (max_beats_lp > 1) ? $clog2(max_beats_lp) : 1;
    localparam int lg_in_lp     = $clog2(in_data_width_p);
    localparam int lg_out_lp    = $clog2(out_data_width_p);
    localparam int lg_w_lp      = $clog2(lg_out_lp + 1);

    typedef enum logic [1:0] {
        e_ready,
        e_data,
        e_out
    } state_e;

    state_e                        state_r, state_n;
    logic [cnt_w_lp-1:0]           cnt_r;
    logic [cnt_w_lp-1:0]           last_cnt_r;
    logic [lg_w_lp-1:0]            lg_fill_r;
    logic [header_width_p-1:0]     header_r;
    logic [out_data_width_p-1:0]   data_r;

    // Decoded fields of the incoming header.
    logic [2:0]                    hdr_size;
    logic [3:0]                    hdr_type;
    logic                          hdr_has_data;
    int                            hdr_lg_bits;
    int                            hdr_lg_fill;
    logic [cnt_w_lp-1:0]           hdr_last_cnt;

    logic                          hdr_fire;
    logic                          beat_fire;
    logic                          out_fire;
    logic                          last_beat;

    assign hdr_size     = in_msg_header_i[size_offset_p +: 3];
    assign hdr_type     = in_msg_header_i[msg_type_offset_p +: 4];
    assign hdr_has_data = payload_mask_p[hdr_type];

    // Message length in bits is 2**(size+3). It is clamped to the block, and
    // anything narrower than one beat still takes exactly one beat.
    always_comb begin
        hdr_lg_bits  = int'(hdr_size) + 3;
        hdr_lg_fill  = (hdr_lg_bits > lg_out_lp) ? lg_out_lp : hdr_lg_bits;
        hdr_last_cnt = '0;
        if (hdr_lg_fill > lg_in_lp)
            hdr_last_cnt = cnt_w_lp'((1 << (hdr_lg_fill - lg_in_lp)) - 1);
    end

    // Readies and valid depend only on state; reset forces them low.
    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // no path through it can infer a latch.
        in_msg_header_ready_and_o = 1'b0;
        in_msg_data_ready_and_o   = 1'b0;
        out_msg_v_o               = 1'b0;
        state_n                   = state_r;

        case (state_r)
            e_ready: in_msg_header_ready_and_o = ~reset_i;
            e_data:  in_msg_data_ready_and_o   = ~reset_i;
            e_out:   out_msg_v_o               = ~reset_i;
            default: ;
        endcase

        hdr_fire  = in_msg_header_v_i & in_msg_header_ready_and_o;
        beat_fire = in_msg_data_v_i   & in_msg_data_ready_and_o;
        out_fire  = out_msg_v_o       & out_msg_ready_and_i;
        last_beat = (cnt_r == last_cnt_r);

        case (state_r)
            e_ready: if (hdr_fire)              state_n = hdr_has_data ? e_data : e_out;
            e_data:  if (beat_fire && last_beat) state_n = e_out;
            e_out:   if (out_fire)              state_n = e_ready;
            default:                             state_n = e_ready;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            // NOTE: the data register is reset (and cleared per header) so an
            // aborted or header-only message can never leak stale payload.
            state_r    <= e_ready;
            cnt_r      <= '0;
            last_cnt_r <= '0;
            lg_fill_r  <= '0;
            header_r   <= '0;
            data_r     <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in
            // this block reading the pre-edge values.
            state_r <= state_n;
            if (hdr_fire) begin
                header_r   <= in_msg_header_i;
                last_cnt_r <= hdr_last_cnt;
                lg_fill_r  <= lg_w_lp'(hdr_lg_fill);
                data_r     <= '0;
                cnt_r      <= '0;
            end
            if (beat_fire) begin
                data_r[cnt_r*in_data_width_p +: in_data_width_p] <= in_msg_data_i;
                cnt_r <= last_beat ? '0 : cnt_r + 1'b1;
            end
        end
    end

    // Replicate the filled low 2**lg_fill_r bits across the whole payload.
    // Fill sizes are powers of two, so a wrap is a simple index mask.
    logic [lg_out_lp-1:0]          fill_mask;
    logic [lg_out_lp-1:0]          src_idx;
    logic [out_data_width_p-1:0]   out_data;

    always_comb begin
        fill_mask = lg_out_lp'((1 << lg_fill_r) - 1);
        src_idx   = '0;
        out_data  = '0;
        for (int i = 0; i < out_data_width_p; i++) begin
            src_idx     = lg_out_lp'(i) & fill_mask;
            out_data[i] = data_r[src_idx];
        end
    end

    assign out_msg_o = {out_data, header_r};

`ifdef BP_ME_BURST_TO_LITE_PROTOCOL_CHECK_EN
    logic [header_width_p+out_data_width_p-1:0] out_prev_r;
    logic                                       stall_prev_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_prev_r <= 1'b0;
            out_prev_r   <= '0;
        end else begin
            if (in_msg_data_v_i && state_r == e_ready)
                $error("burst_to_lite: data valid in e_ready state=%0d header=%h",
                       state_r, header_r);
            if (hdr_fire && hdr_lg_bits > lg_out_lp)
                $error("burst_to_lite: header size exceeds block state=%0d header=%h",
                       state_r, in_msg_header_i);
            if (stall_prev_r && out_msg_o != out_prev_r)
                $error("burst_to_lite: out_msg changed under backpressure state=%0d header=%h",
                       state_r, header_r);
            stall_prev_r <= out_msg_v_o & ~out_msg_ready_and_i;
            out_prev_r   <= out_msg_o;
        end
    end
`else
    // Protocol checks not compiled; behaviour is unchanged.
`endif

endmodule

// File: tb/tb_bp_me_burst_to_lite.sv
// Directed self-checking bench for bp_me_burst_to_lite.
// Header layout used here: {tag[8:0], msg_type[3:0], msg_size[2:0]}.
// msg_type 1 carries data (payload mask 16'h0002); msg_type 0 does not.

module tb_bp_me_burst_to_lite;

    localparam int HW  = 16;
    localparam int IW  = 64;
    localparam int OW  = 512;
    localparam int MW  = HW + OW;

    logic          clk_i;
    logic          reset_i;
    logic [HW-1:0] in_msg_header_i;
    logic          in_msg_header_v_i;
    logic          in_msg_header_ready_and_o;
    logic [IW-1:0] in_msg_data_i;
    logic          in_msg_data_v_i;
    logic          in_msg_data_ready_and_o;
    logic [MW-1:0] out_msg_o;
    logic          out_msg_v_o;
    logic          out_msg_ready_and_i;

    int n_checks = 0;
    int n_errors = 0;

    bp_me_burst_to_lite #(
        .header_width_p   (HW),
        .in_data_width_p  (IW),
        .out_data_width_p (OW),
        .size_offset_p    (0),
        .msg_type_offset_p(3),
        .payload_mask_p   (16'h0002)
    ) dut (
        .clk_i                    (clk_i),
        .reset_i                  (reset_i),
        .in_msg_header_i          (in_msg_header_i),
        .in_msg_header_v_i        (in_msg_header_v_i),
        .in_msg_header_ready_and_o(in_msg_header_ready_and_o),
        .in_msg_data_i            (in_msg_data_i),
        .in_msg_data_v_i          (in_msg_data_v_i),
        .in_msg_data_ready_and_o  (in_msg_data_ready_and_o),
        .out_msg_o                (out_msg_o),
        .out_msg_v_o              (out_msg_v_o),
        .out_msg_ready_and_i      (out_msg_ready_and_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [HW-1:0] mk_hdr(input logic [3:0] typ, input logic [2:0] sz,
                                             input logic [8:0] tag);
        return {tag, typ, sz};
    endfunction

    // All tasks start and end at a falling edge.
    task automatic send_header(input logic [HW-1:0] h);
        int n = 0;
        in_msg_header_i   = h;
        in_msg_header_v_i = 1'b1;
        while (!in_msg_header_ready_and_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n == 50) check("hdr_timeout", 0, 1);
        @(negedge clk_i);
        in_msg_header_v_i = 1'b0;
    endtask

    task automatic send_beat(input logic [IW-1:0] d, input int gap);
        int n = 0;
        repeat (gap) @(negedge clk_i);
        in_msg_data_i   = d;
        in_msg_data_v_i = 1'b1;
        while (!in_msg_data_ready_and_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n == 50) check("beat_timeout", 0, 1);
        @(negedge clk_i);
        in_msg_data_v_i = 1'b0;
    endtask

    task automatic take_out(input string tag);
        out_msg_ready_and_i = 1'b1;
        @(negedge clk_i);
        out_msg_ready_and_i = 1'b0;
        check({tag, "_v_drop"}, out_msg_v_o, 1'b0);
        check({tag, "_hdr_rdy"}, in_msg_header_ready_and_o, 1'b1);
    endtask

    logic [HW-1:0] h, h2;
    logic [OW-1:0] exp;
    logic [IW-1:0] b0, b1, b2, b3;
    int            g0, g1;

    initial begin
        reset_i             = 1'b1;
        in_msg_header_i     = '0;
        in_msg_header_v_i   = 1'b0;
        in_msg_data_i       = '0;
        in_msg_data_v_i     = 1'b0;
        out_msg_ready_and_i = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk_i);
        check("rst_hdr_rdy",  in_msg_header_ready_and_o, 1'b0);
        check("rst_data_rdy", in_msg_data_ready_and_o,   1'b0);
        check("rst_out_v",    out_msg_v_o,               1'b0);
        check("rst_out_msg",  out_msg_o,                 '0);
        reset_i = 1'b0;
        @(negedge clk_i);
        check("idle_hdr_rdy",  in_msg_header_ready_and_o, 1'b1);
        check("idle_data_rdy", in_msg_data_ready_and_o,   1'b0);
        check("idle_out_v",    out_msg_v_o,               1'b0);

        // Header-only read of 64 B.
        h = mk_hdr(4'd0, 3'd6, 9'h15A);
        send_header(h);
        check("ro_v",        out_msg_v_o,               1'b1);
        check("ro_msg",      out_msg_o,                 {{OW{1'b0}}, h});
        check("ro_hdr_rdy",  in_msg_header_ready_and_o, 1'b0);
        check("ro_data_rdy", in_msg_data_ready_and_o,   1'b0);
        take_out("ro");

        // Full-block write: beats 7 down to 0.
        h = mk_hdr(4'd1, 3'd6, 9'h0C3);
        send_header(h);
        check("fb_data_rdy", in_msg_data_ready_and_o, 1'b1);
        for (int k = 0; k < 8; k++) begin
            send_beat(64'(7 - k), 0);
            if (k == 6) check("fb_v_early", out_msg_v_o, 1'b0);
        end
        check("fb_v", out_msg_v_o, 1'b1);
        exp = {64'd0, 64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7};
        check("fb_msg", out_msg_o, {exp, h});
        take_out("fb");

        // Sub-beat write of 1 B.
        h = mk_hdr(4'd1, 3'd0, 9'h1F0);
        send_header(h);
        send_beat(64'h0000_0000_0000_00AB, 0);
        check("sb_v",        out_msg_v_o,             1'b1);
        check("sb_data_rdy", in_msg_data_ready_and_o, 1'b0);
        check("sb_msg",      out_msg_o,               {{64{8'hAB}}, h});
        take_out("sb");

        // 32 B (4-beat) write followed by 5 cycles of backpressure.
        b0 = 64'h1111_2222_3333_4444;
        b1 = 64'h5555_6666_7777_8888;
        b2 = 64'h9999_AAAA_BBBB_CCCC;
        b3 = 64'hDDDD_EEEE_FFFF_0000;
        h  = mk_hdr(4'd1, 3'd5, 9'h0AA);
        h2 = mk_hdr(4'd1, 3'd3, 9'h055);
        send_header(h);
        send_beat(b0, 0);
        send_beat(b1, 0);
        send_beat(b2, 0);
        send_beat(b3, 0);
        exp = {b3, b2, b1, b0, b3, b2, b1, b0};
        in_msg_header_i   = h2;
        in_msg_header_v_i = 1'b1;
        in_msg_data_i     = 64'h0123_4567_89AB_CDEF;
        in_msg_data_v_i   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("bp_msg",      out_msg_o,                 {exp, h});
            check("bp_v",        out_msg_v_o,               1'b1);
            check("bp_hdr_rdy",  in_msg_header_ready_and_o, 1'b0);
            check("bp_data_rdy", in_msg_data_ready_and_o,   1'b0);
            @(negedge clk_i);
        end
        in_msg_data_v_i     = 1'b0;
        out_msg_ready_and_i = 1'b1;
        @(negedge clk_i);
        out_msg_ready_and_i = 1'b0;
        check("bp_v_drop",    out_msg_v_o,               1'b0);
        check("bp_hdr2_rdy",  in_msg_header_ready_and_o, 1'b1);
        @(negedge clk_i);
        in_msg_header_v_i = 1'b0;
        check("bp_hdr2_taken", in_msg_data_ready_and_o, 1'b1);
        send_beat(64'h0123_4567_89AB_CDEF, 0);
        check("bp2_msg", out_msg_o, {{8{64'h0123_4567_89AB_CDEF}}, h2});
        take_out("bp2");

        // Reset after 3 of 8 beats, then a fresh 8-beat write.
        h = mk_hdr(4'd1, 3'd6, 9'h1DE);
        send_header(h);
        for (int k = 0; k < 3; k++) send_beat(64'hDEAD_BEEF_0000_0000 | 64'(k), 0);
        reset_i = 1'b1;
        @(negedge clk_i);
        check("mr_rst_hdr_rdy", in_msg_header_ready_and_o, 1'b0);
        check("mr_rst_out_v",   out_msg_v_o,               1'b0);
        check("mr_rst_msg",     out_msg_o,                 '0);
        reset_i = 1'b0;
        @(negedge clk_i);
        check("mr_hdr_rdy",  in_msg_header_ready_and_o, 1'b1);
        check("mr_data_rdy", in_msg_data_ready_and_o,   1'b0);
        h = mk_hdr(4'd1, 3'd6, 9'h033);
        send_header(h);
        for (int k = 0; k < 8; k++) send_beat(64'hC0DE_0000_0000_0000 | 64'(k), 0);
        check("mr_v", out_msg_v_o, 1'b1);
        exp = {64'hC0DE_0000_0000_0007, 64'hC0DE_0000_0000_0006,
               64'hC0DE_0000_0000_0005, 64'hC0DE_0000_0000_0004,
               64'hC0DE_0000_0000_0003, 64'hC0DE_0000_0000_0002,
               64'hC0DE_0000_0000_0001, 64'hC0DE_0000_0000_0000};
        check("mr_msg", out_msg_o, {exp, h});
        take_out("mr");

        // 16 B (2-beat) write with random idle gaps between beats.
        b0 = 64'hA5A5_0000_FFFF_1234;
        b1 = 64'h5A5A_1111_EEEE_5678;
        g0 = $urandom_range(0, 3);
        g1 = $urandom_range(0, 3);
        h  = mk_hdr(4'd1, 3'd4, 9'h101);
        send_header(h);
        send_beat(b0, g0);
        check("gap_v_mid", out_msg_v_o, 1'b0);
        send_beat(b1, g1);
        check("gap_v", out_msg_v_o, 1'b1);
        check("gap_msg", out_msg_o, {{4{b1, b0}}, h});
        take_out("gap");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
